// File: rtl/router_reg.sv
// Router datapath register stage: header/payload/parity capture, parked byte on FIFO full, parity check.
// Latency: dout one cycle after lfd_state/ld_state; err one cycle after parity_done. No backpressure of its own; fifo_full parks one byte.
// Optional ROUTER_REG_ERR_CNT_EN adds a saturating err_count output.
module router_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_int_reg,
   output logic                  parity_done,
   output logic                  low_packet_valid,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] dout
`ifdef ROUTER_REG_ERR_CNT_EN
   ,
   output logic [7:0]            err_count
`endif
);

   logic [DATA_WIDTH-1:0] header_q, header_d;
   logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
   logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
   logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  parity_done_q, parity_done_d;
   logic                  low_pkt_q, low_pkt_d;
   logic                  err_q, err_d;

   always_comb begin
      header_d = header_q;
      if (detect_add && pkt_valid && (data_in[1:0] != 2'b11))
         header_d = data_in;

      dout_d = dout_q;
      if (lfd_state)
         dout_d = header_q;
      else if (ld_state && !fifo_full)
         dout_d = data_in;
      else if (laf_state)
         dout_d = full_byte_q;

      full_byte_d = full_byte_q;
      if (ld_state && fifo_full)
         full_byte_d = data_in;

      // A parked payload byte joins the running parity only when it is replayed.
      int_parity_d = int_parity_q;
      if (detect_add)
         int_parity_d = '0;
      else if (lfd_state)
         int_parity_d = int_parity_q ^ header_q;
      else if (ld_state && pkt_valid && !full_state && !fifo_full)
         int_parity_d = int_parity_q ^ data_in;
      else if (laf_state && !low_pkt_q)
         int_parity_d = int_parity_q ^ full_byte_q;

      pkt_parity_d = pkt_parity_q;
      if (ld_state && !pkt_valid && !fifo_full)
         pkt_parity_d = data_in;
      else if (laf_state && low_pkt_q)
         pkt_parity_d = full_byte_q;

      parity_done_d = parity_done_q;
      if (detect_add)
         parity_done_d = 1'b0;
      else if (ld_state && !pkt_valid && !fifo_full)
         parity_done_d = 1'b1;
      else if (laf_state && low_pkt_q && !parity_done_q)
         parity_done_d = 1'b1;

      low_pkt_d = low_pkt_q;
      if (rst_int_reg)
         low_pkt_d = 1'b0;
      else if (ld_state && !pkt_valid)
         low_pkt_d = 1'b1;

      err_d = err_q;
      if (detect_add)
         err_d = 1'b0;
      else if (parity_done_q && (int_parity_q != pkt_parity_q))
         err_d = 1'b1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         header_q      <= '0;
         full_byte_q   <= '0;
         int_parity_q  <= '0;
         pkt_parity_q  <= '0;
         dout_q        <= '0;
         parity_done_q <= 1'b0;
         low_pkt_q     <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         header_q      <= header_d;
         full_byte_q   <= full_byte_d;
         int_parity_q  <= int_parity_d;
         pkt_parity_q  <= pkt_parity_d;
         dout_q        <= dout_d;
         parity_done_q <= parity_done_d;
         low_pkt_q     <= low_pkt_d;
         err_q         <= err_d;
      end
   end

   assign dout             = dout_q;
   assign parity_done      = parity_done_q;
   assign low_packet_valid = low_pkt_q;
   assign err              = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (err_d && !err_q && (err_count_q != 8'hFF))
         err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         err_count_q <= 8'h00;
      else
         err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: acts as router_fsm, drives whole packets and checks against a packet-level model.
module tb_router_reg;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       fifo_full;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       rst_int_reg;
   logic       parity_done;
   logic       low_packet_valid;
   logic       err;
   logic [7:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
   logic [7:0] err_count;
`endif

   int errors = 0;
   int checks = 0;

   // Packet-level model state
   logic [7:0] hdr_ref;
   int         cnt_ref;
   logic [7:0] pay [0:7];
   int         plen;

   always #5 clock = ~clock;

   router_reg #(.DATA_WIDTH(8)) dut (
      .clock            (clock),
      .resetn           (resetn),
      .pkt_valid        (pkt_valid),
      .data_in          (data_in),
      .fifo_full        (fifo_full),
      .detect_add       (detect_add),
      .lfd_state        (lfd_state),
      .ld_state         (ld_state),
      .laf_state        (laf_state),
      .full_state       (full_state),
      .rst_int_reg      (rst_int_reg),
      .parity_done      (parity_done),
      .low_packet_valid (low_packet_valid),
      .err              (err),
      .dout             (dout)
`ifdef ROUTER_REG_ERR_CNT_EN
      ,
      .err_count        (err_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      pkt_valid   = 1'b0;
      fifo_full   = 1'b0;
      detect_add  = 1'b0;
      lfd_state   = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      rst_int_reg = 1'b0;
      data_in     = 8'($urandom);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // stall: index of the byte (payload 0..plen-1, parity = plen) that meets a full FIFO; -1 for none.
   task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] par, input int stall);
      logic [7:0] last;
      logic [7:0] exp_par;
      logic [7:0] b;
      logic       pv;
      logic       exp_err;

      idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
      tick();
      if (hdr[1:0] != 2'b11) hdr_ref = hdr;
      check("pdone_clr", {31'd0, parity_done}, 32'd0);
      check("err_clr", {31'd0, err}, 32'd0);

      idle(); lfd_state = 1'b1; pkt_valid = 1'b1; data_in = pay[0];
      tick();
      check("hdr_dout", {24'd0, dout}, {24'd0, hdr_ref});
      last    = hdr_ref;
      exp_par = hdr_ref;

      for (int i = 0; i <= plen; i++) begin
         pv = (i < plen);
         b  = pv ? pay[i] : par;
         idle(); ld_state = 1'b1; pkt_valid = pv; data_in = b; fifo_full = (i == stall);
         tick();
         if (i == stall) begin
            check("stall_hold", {24'd0, dout}, {24'd0, last});
            if (!pv) check("lpv_full", {31'd0, low_packet_valid}, 32'd1);
            idle(); full_state = 1'b1; pkt_valid = pv; data_in = ~b;
            tick();
            check("full_hold", {24'd0, dout}, {24'd0, last});
            idle(); laf_state = 1'b1; pkt_valid = pv; data_in = ~b;
            tick();
            check("laf_dout", {24'd0, dout}, {24'd0, b});
         end else begin
            check("ld_dout", {24'd0, dout}, {24'd0, b});
         end
         last = b;
         if (pv) exp_par = exp_par ^ b;
      end

      check("lpv_set", {31'd0, low_packet_valid}, 32'd1);
      check("pdone_set", {31'd0, parity_done}, 32'd1);
      check("err_early", {31'd0, err}, 32'd0);

      idle(); rst_int_reg = 1'b1;
      tick();
      exp_err = (exp_par != par);
      check("err", {31'd0, err}, {31'd0, exp_err});
      check("lpv_clr", {31'd0, low_packet_valid}, 32'd0);
`ifdef ROUTER_REG_ERR_CNT_EN
      if (exp_err && cnt_ref < 255) cnt_ref++;
      check("err_count", {24'd0, err_count}, cnt_ref);
`endif
      idle();
      tick();
      check("err_hold", {31'd0, err}, {31'd0, exp_err});
   endtask

   initial begin
      logic [7:0] h;
      logic [7:0] p;
      int         st;

      idle();
      resetn  = 1'b0;
      hdr_ref = 8'h00;
      cnt_ref = 0;
      tick(); tick();
      check("rst_dout", {24'd0, dout}, 32'd0);
      check("rst_flags", {29'd0, parity_done, low_packet_valid, err}, 32'd0);
      resetn = 1'b1;
      tick();

      // T1: asynchronous reset in the middle of a packet
      idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; tick();
      idle(); lfd_state = 1'b1; pkt_valid = 1'b1; tick();
      idle(); ld_state = 1'b1; pkt_valid = 1'b0; data_in = 8'h11; tick();
      check("pre_rst_dout", {24'd0, dout}, 32'h11);
      #2 resetn = 1'b0;
      #1;
      check("async_dout", {24'd0, dout}, 32'd0);
      check("async_flags", {29'd0, parity_done, low_packet_valid, err}, 32'd0);
      idle();
      tick();
      resetn = 1'b1;
      hdr_ref = 8'h00;
      idle(); lfd_state = 1'b1; tick();
      check("rst_header", {24'd0, dout}, 32'd0);
      idle(); tick();

      // T2..T5 directed packets
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; plen = 3;
      run_pkt(8'h0D, 8'h0D, -1);
      run_pkt(8'h0D, 8'h0E, -1);
      run_pkt(8'h0D, 8'h0D, 1);
      run_pkt(8'h0D, 8'h0D, 3);

      // T6: invalid address leaves the captured header untouched
      idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h03; tick();
      idle(); lfd_state = 1'b1; tick();
      check("bad_addr_hdr", {24'd0, dout}, {24'd0, hdr_ref});
      idle(); tick();

      // Random packets
      for (int n = 0; n < 40; n++) begin
         plen = $urandom_range(1, 6);
         for (int k = 0; k < 8; k++) pay[k] = 8'($urandom);
         h = 8'($urandom);
         h[1:0] = 2'($urandom_range(0, 2));
         p = h;
         for (int k = 0; k < plen; k++) p = p ^ pay[k];
         if ($urandom_range(0, 1) == 1) p = p ^ 8'($urandom_range(1, 255));
         st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, plen)) : -1;
         run_pkt(h, p, st);
      end

`ifdef ROUTER_REG_ERR_CNT_EN
      // Saturation of the error counter
      plen = 1;
      for (int n = 0; n < 260; n++) begin
         pay[0] = 8'($urandom);
         run_pkt(8'h01, 8'h01 ^ pay[0] ^ 8'h80, -1);
      end
      check("err_count_sat", {24'd0, err_count}, 32'hFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
